// File: rtl/bf_pkg.sv
// Shared encodings for the byte memory bridge: FSM states, bus phases and
// the default handshake timeout.
package bf_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] PH_ADDR_HI = 2'd0;
  localparam logic [1:0] PH_ADDR_LO = 2'd1;
  localparam logic [1:0] PH_DATA    = 2'd2;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/ack_sync.sv
// Two-flop synchronizer for the off-chip ack; free-running so that en
// never stalls metastability settling.
module ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bf_mem_bridge.sv
// Byte read/write responder for the core: runs ADDR_HI, ADDR_LO, DATA phases
// over an 8-bit bus with a 4-phase stb/ack handshake and a per-wait timeout.
//
// state   | meaning
// IDLE    | waiting for req with synchronized ack low
// ASSERT  | strobe high, waiting for ack_s rise
// RELEASE | strobe low, waiting for ack_s fall
// RESP    | one-cycle done pulse, err valid
module bf_mem_bridge
  import bf_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        err,
  output logic        ext_stb,
  output logic        ext_we,
  input  logic        ext_ack,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  input  logic [7:0]  bus_in
);

  state_t            state_q, state_d;
  logic [1:0]        phase_q;
  logic [TO_W-1:0]   cnt_q;
  logic              we_q;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        hold_q;
  logic [7:0]        rdata_q;
  logic              err_q;
  logic              ack_s;
  logic              accept, capture, phase_inc, abort, to_hit;
  logic              busy, drive;

  ack_sync u_ack_sync (
    .clk   (clk),
    .rst   (reset),
    .d     (ext_ack),
    .q     (ack_s)
  );

  assign to_hit = (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    phase_inc = 1'b0;
    abort     = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (req && !ack_s) begin
            state_d = S_ASSERT;
            accept  = 1'b1;
          end
        end
        S_ASSERT: begin
          if (ack_s) begin
            state_d = S_RELEASE;
            capture = (phase_q == PH_DATA) && !we_q;
          end else if (to_hit) begin
            state_d = S_RESP;
            abort   = 1'b1;
          end
        end
        S_RELEASE: begin
          if (!ack_s) begin
            if (phase_q != PH_DATA) begin
              state_d   = S_ASSERT;
              phase_inc = 1'b1;
            end else begin
              state_d = S_RESP;
            end
          end else if (to_hit) begin
            state_d = S_RESP;
            abort   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_ADDR_HI;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      hold_q  <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Each wait state gets its own full timeout budget.
      if (state_d != state_q)
        cnt_q <= '0;
      else if (en && (state_q == S_ASSERT || state_q == S_RELEASE))
        cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        phase_q <= PH_ADDR_HI;
      end else if (phase_inc) begin
        phase_q <= phase_q + 2'd1;
      end
      if (capture)
        hold_q <= bus_in;
      if (state_d == S_RESP && state_q != S_RESP) begin
        err_q <= abort;
        if (!we_q)
          rdata_q <= abort ? 8'h00 : hold_q;
      end
    end
  end

  assign busy    = (state_q == S_ASSERT) || (state_q == S_RELEASE);
  assign drive   = busy && !((phase_q == PH_DATA) && !we_q);
  assign ext_stb = (state_q == S_ASSERT);
  assign ext_we  = (state_q != S_IDLE) && we_q;
  assign bus_oe  = drive;
  assign done    = (state_q == S_RESP);
  assign err     = err_q;
  assign rdata   = rdata_q;

  always_comb begin
    bus_out = 8'h00;
    if (drive) begin
      case (phase_q)
        PH_ADDR_HI: bus_out = addr_q[15:8];
        PH_ADDR_LO: bus_out = addr_q[7:0];
        default:    bus_out = wdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_mem_bridge.sv
// Scoreboard bench for bf_mem_bridge: stimulus pushes expected strobes and
// responses, a forked monitor pops and compares as the DUT presents them.
module tb_bf_mem_bridge;

  typedef struct {
    int         lat;
    logic       err;
    logic [7:0] rdata;
  } done_exp_t;

  typedef struct {
    logic [7:0] bo;
    logic       oe;
    logic       we;
  } stb_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1, req = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00, bus_in = 8'h00;
  logic [7:0]  rdata, bus_out;
  logic        done, err, ext_stb, ext_we, bus_oe;
  logic        ext_ack = 1'b0;

  logic        req8 = 1'b0, we8 = 1'b0;
  logic [15:0] addr8 = 16'h0000;
  logic [7:0]  wdata8 = 8'h00;
  logic [7:0]  rdata8, bus_out8;
  logic        done8, err8, ext_stb8, ext_we8, bus_oe8;
  logic        ext_ack8 = 1'b0;

  int cyc = 0;
  int t0 = 0, t08 = 0;
  int extra = 0, extra8 = 10;
  int wcnt = 0, wcnt8 = 0;
  logic no_ack = 1'b0;
  int n_vec = 0, n_mis = 0;
  int ndone = 0, ndone8 = 0;

  done_exp_t exp_q[$];
  done_exp_t exp8_q[$];
  stb_exp_t  strb_q[$];

  bf_mem_bridge dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .ext_stb(ext_stb),
    .ext_we(ext_we), .ext_ack(ext_ack), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in)
  );

  bf_mem_bridge #(.TIMEOUT(8), .TO_W(8)) dut8 (
    .clk(clk), .reset(reset), .en(1'b1), .req(req8), .we(we8), .addr(addr8),
    .wdata(wdata8), .rdata(rdata8), .done(done8), .err(err8), .ext_stb(ext_stb8),
    .ext_we(ext_we8), .ext_ack(ext_ack8), .bus_out(bus_out8), .bus_oe(bus_oe8),
    .bus_in(8'h00)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference responder: ack = stb registered once, with optional extra rise delay.
  always @(posedge clk) begin
    if (!ext_stb) begin
      ext_ack <= 1'b0;
      wcnt    <= 0;
    end else if (!no_ack && !ext_ack) begin
      if (wcnt >= extra) ext_ack <= 1'b1;
      else               wcnt <= wcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!ext_stb8) begin
      ext_ack8 <= 1'b0;
      wcnt8    <= 0;
    end else if (!ext_ack8) begin
      if (wcnt8 >= extra8) ext_ack8 <= 1'b1;
      else                 wcnt8 <= wcnt8 + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic prev_stb = 1'b0;
    logic chk1 = 1'b0;
    logic chk18 = 1'b0;
    done_exp_t e;
    stb_exp_t  s;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (chk1) begin
          chk("done_width", int'(done), 0);
          chk1 = 1'b0;
        end else if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_latency", cyc - t0, e.lat);
            chk("err", int'(err), int'(e.err));
            chk("rdata", int'(rdata), int'(e.rdata));
            chk("stb_in_resp", int'(ext_stb), 0);
            chk("oe_in_resp", int'(bus_oe), 0);
          end
          ndone++;
          chk1 = 1'b1;
        end
        if (ext_stb && !prev_stb) begin
          if (strb_q.size() == 0) begin
            chk("unexpected_stb", 1, 0);
          end else begin
            s = strb_q.pop_front();
            chk("stb_oe", int'(bus_oe), int'(s.oe));
            chk("stb_we", int'(ext_we), int'(s.we));
            if (s.oe) chk("stb_bus_out", int'(bus_out), int'(s.bo));
          end
        end
        if (chk18) begin
          chk("done8_width", int'(done8), 0);
          chk18 = 1'b0;
        end else if (done8) begin
          if (exp8_q.size() == 0) begin
            chk("unexpected_done8", 1, 0);
          end else begin
            e = exp8_q.pop_front();
            chk("done8_latency", cyc - t08, e.lat);
            chk("err8", int'(err8), int'(e.err));
            chk("rdata8", int'(rdata8), int'(e.rdata));
          end
          ndone8++;
          chk18 = 1'b1;
        end
      end
      prev_stb = ext_stb;
    end
  endtask

  task automatic push_done(input int lat, input logic e, input logic [7:0] rd);
    done_exp_t x;
    x.lat = lat; x.err = e; x.rdata = rd;
    exp_q.push_back(x);
  endtask

  task automatic push_stb(input logic [7:0] bo, input logic oe, input logic w);
    stb_exp_t x;
    x.bo = bo; x.oe = oe; x.we = w;
    strb_q.push_back(x);
  endtask

  task automatic push_xfer(input logic w, input logic [15:0] a, input logic [7:0] d);
    push_stb(a[15:8], 1'b1, w);
    push_stb(a[7:0], 1'b1, w);
    push_stb(d, w, w);
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    t0 = cyc; we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic goto(input int c);
    int guard = 0;
    while (cyc < c && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic wait_done(input int target, input logic which8, input string nm);
    int k = 0;
    while (((which8 ? ndone8 : ndone) < target) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if ((which8 ? ndone8 : ndone) < target) chk({nm, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    #12;
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_stb", int'(ext_stb), 0);
    chk("rst_we", int'(ext_we), 0);
    chk("rst_oe", int'(bus_oe), 0);
    chk("rst_bus_out", int'(bus_out), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // write 1234/A5
    push_xfer(1'b1, 16'h1234, 8'hA5);
    push_done(25, 1'b0, 8'h00);
    issue(1'b1, 16'h1234, 8'hA5);
    wait_done(1, 1'b0, "wr_ref");

    // read 00FF, responder returns 3C
    bus_in = 8'h3C;
    push_xfer(1'b0, 16'h00FF, 8'h00);
    push_done(25, 1'b0, 8'h3C);
    issue(1'b0, 16'h00FF, 8'h00);
    wait_done(2, 1'b0, "rd_ref");

    // no ack ever: abort in phase 0 with rdata cleared
    no_ack = 1'b1;
    push_stb(8'hAB, 1'b1, 1'b0);
    push_done(256, 1'b1, 8'h00);
    issue(1'b0, 16'hABCD, 8'h00);
    goto(t0 + 255);
    @(negedge clk);
    chk("stb_at_255", int'(ext_stb), 1);
    wait_done(3, 1'b0, "timeout");
    no_ack = 1'b0;

    // en low for 5 cycles at the end of phase-1 ASSERT
    bus_in = 8'h5A;
    push_xfer(1'b0, 16'h5500, 8'h00);
    push_done(30, 1'b0, 8'h5A);
    issue(1'b0, 16'h5500, 8'h00);
    goto(t0 + 12);
    en = 1'b0;
    goto(t0 + 15);
    chk("en_hold_stb", int'(ext_stb), 1);
    chk("en_hold_bus", int'(bus_out), 8'h00);
    goto(t0 + 17);
    en = 1'b1;
    wait_done(4, 1'b0, "en_stall");

    // reset during phase-2 write, then a clean write
    push_xfer(1'b1, 16'h4321, 8'h99);
    issue(1'b1, 16'h4321, 8'h99);
    goto(t0 + 18);
    @(negedge clk);
    chk("pre_rst_stb", int'(ext_stb), 1);
    reset = 1'b1;
    #1;
    chk("midrst_stb", int'(ext_stb), 0);
    chk("midrst_oe", int'(bus_oe), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_we", int'(ext_we), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    push_xfer(1'b1, 16'h0001, 8'h7E);
    push_done(25, 1'b0, 8'h00);
    issue(1'b1, 16'h0001, 8'h7E);
    wait_done(5, 1'b0, "post_rst_wr");

    // ack rise delayed by 10 extra cycles in phase 0
    bus_in = 8'hC3;
    extra = 10;
    push_xfer(1'b0, 16'hBEEF, 8'h00);
    push_done(35, 1'b0, 8'hC3);
    issue(1'b0, 16'hBEEF, 8'h00);
    goto(t0 + 14);
    extra = 0;
    wait_done(6, 1'b0, "ack_delay");

    // same delay against TIMEOUT=8 aborts in phase 0
    exp8_q.push_back('{lat: 9, err: 1'b1, rdata: 8'h00});
    @(posedge clk); #1;
    t08 = cyc; we8 = 1'b1; addr8 = 16'hBEEF; wdata8 = 8'h11; req8 = 1'b1;
    @(posedge clk); #1;
    req8 = 1'b0;
    wait_done(1, 1'b1, "to8_abort");

    repeat (5) @(posedge clk);
    chk("sb_empty", exp_q.size() + exp8_q.size() + strb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/bf_mem_bridge.md
Name: bf_mem_bridge

Overview:
- Responder side of the processor control FSM's memory interface.
- Accepts one byte read or write request from the core: address, write flag and write data.
- Executes the request over a narrow 8-bit off-chip bus using a 4-phase strobe/ack handshake.
- Returns read data plus a one-cycle done pulse and an error flag. Sits between the core datapath (addr mux, data mux) and the uio pins.

Parameters:
- TIMEOUT, 255, max enabled cycles spent waiting in any single handshake wait state before abort.
- TO_W, 8, width of timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable; state, counter and outputs frozen when 0
- req  in  1  core request, level; sampled only in IDLE
- we  in  1  1=write, 0=read; latched at accept
- addr  in  16  byte address; latched at accept
- wdata  in  8  write data; latched at accept
- rdata  out  8  last successful read data
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1=timeout abort
- ext_stb  out  1  off-chip strobe
- ext_we  out  1  transaction direction, held for whole transaction
- ext_ack  in  1  off-chip ack, asynchronous to clk
- bus_out  out  8  off-chip bus drive value
- bus_oe  out  1  bus output enable
- bus_in  in  8  off-chip bus sample

Behaviour:
- Reset values (asynchronous): state=IDLE, phase=0, counter=0, rdata=8'h00, done=0, err=0, ext_stb=0, ext_we=0, bus_out=8'h00, bus_oe=0.
- ext_ack passes through a 2-flop synchronizer (ack_s). The FSM uses only ack_s.
- Phases in order: 0=ADDR_HI (bus_out=addr[15:8]), 1=ADDR_LO (addr[7:0]), 2=DATA (wdata on write; bus released on read).
- IDLE:
  - If en & req & ~ack_s: latch we/addr/wdata, phase=0, go ASSERT.
  - If ack_s is still high from an earlier aborted transaction, the request stays pending.
- ASSERT:
  - ext_stb=1.
  - bus_oe=1, except phase 2 with we=0.
  - When ack_s=1:
    - In phase 2 read, capture bus_in into a holding register.
    - Go RELEASE.
- RELEASE:
  - ext_stb=0, bus_out held, bus_oe as in ASSERT.
  - When ack_s=0: if phase<2, phase++ and go ASSERT; else go RESP with err=0.
- RESP:
  - done=1 for exactly one cycle, then IDLE.
  - On successful read, rdata updates from the holding register in the RESP cycle.
  - Writes leave rdata unchanged.
- Timeout:
  - Counter clears on every state entry and increments each enabled cycle in ASSERT/RELEASE.
  - If counter==TIMEOUT-1 and the awaited ack_s level is absent: go RESP with err=1, drop ext_stb and bus_oe.
  - On a read abort, rdata=8'h00.
- ext_we=latched we from ASSERT of phase 0 through RESP; 0 in IDLE.
- en=0: no state, phase, counter or capture change; outputs hold. The synchronizer runs regardless.
- req while busy: ignored. Core must drop req by the done cycle, otherwise a new transaction is accepted in the following IDLE cycle.
- Reference latency: responder with ext_ack = stb registered once.
  - Each ASSERT and each RELEASE lasts 4 cycles.
  - Req accepted at cycle 0 → done in cycle 25.
- Reset mid-transaction: outputs drop immediately. No partial response is given; the external side must tolerate stb loss.

Decomposition:
- bf_pkg holds:
  - state encoding (IDLE, ASSERT, RELEASE, RESP; 2 bits)
  - phase constants PH_ADDR_HI=0, PH_ADDR_LO=1, PH_DATA=2
  - default TIMEOUT
- One sub-module: ack_sync, a 2-flop synchronizer with async active-high reset to 0.

Test Plan:
- Reference responder, write addr=16'h1234 wdata=8'hA5 → bus_out sequence 8'h12, 8'h34, 8'hA5 with bus_oe=1 on each strobe, ext_we=1; done at cycle 25, err=0, rdata unchanged.
- Reference responder returns 8'h3C, read addr=16'h00FF → bus_out 8'h00, 8'hFF, then bus_oe=0 in data phase; done at cycle 25 with rdata=8'h3C, err=0, done high exactly 1 cycle.
- Responder never acks, read, TIMEOUT=255 → ext_stb high for cycles 1..255; done at cycle 256 with err=1, rdata=8'h00, ext_stb=0 and bus_oe=0 from cycle 256.
- en=0 for 5 cycles during phase-1 ASSERT → ext_stb, bus_out and counter hold; done at cycle 30; data correct.
- reset asserted during phase 2 of a write → ext_stb, bus_oe, done and ext_we go 0 asynchronously. After release, write 16'h0001/8'h7E completes normally at cycle 25.
- Responder delays its ack rise by 10 extra cycles in phase 0 → done at cycle 35, err=0. With TIMEOUT=8, the same stimulus aborts with err=1 in phase 0.
